rgb_stream_feeder: RTL and testbench
====================================

# rgb_stream_feeder

Pixel-rate buffer that sits directly upstream of the HDMI control path. It accepts a valid/ready RGB888 pixel stream carrying a start-of-frame marker, and holds the pixels in a small FIFO. It delivers one pixel per `pixel_de` request on `rgb_data`, aligning each frame to the `pixel_start_flag` pulse from the timing generator. Underflow and frame misalignment are detected, blanked and reported.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO entries; power of two, minimum 4.
- `BLANK_RGB`, 24'h000000 — value driven on underflow or misalignment.

Ports:
- `clkin` input 1 — pixel clock (clkx1 domain); the block's only clock.
- `rstin` input 1 — asynchronous, active-high reset.
- `s_data` input 24 — upstream pixel, {R,G,B}, 8 bits each.
- `s_sof` input 1 — qualifies `s_data` as the first pixel of a frame.
- `s_valid` input 1 — upstream pixel valid.
- `s_ready` output 1 — FIFO can accept a pixel.
- `pixel_start_flag` input 1 — one-cycle frame-start pulse from the timing generator.
- `pixel_de` input 1 — active-video pixel request.
- `rgb_data` output 24 — registered pixel to the timing generator.
- `frame_err` output 1 — one-cycle pulse on a detected frame misalignment.
- `underflow_cnt` output 16 — saturating count of pixels requested while the FIFO was empty in RUN.

## Operation
- **FIFO**
  - Entries are 25 bits: {sof, data}.
  - Push occurs when `s_valid & s_ready`.
  - `s_ready = ~full`, forced to 0 while `rstin` is high.
  - Occupancy counter is log2(DEPTH)+1 bits wide; read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - A push is never accepted while full, even if a pop happens in that cycle.
- **States**: WAIT_SOF, ARMED, RUN.
- **WAIT_SOF** (reset state)
  - If the head entry is non-empty with sof=0, pop it (discard), one per cycle.
  - If the head entry has sof=1, go to ARMED.
  - `pixel_de` yields BLANK_RGB.
- **ARMED**
  - Hold the SOF head entry.
  - On `pixel_start_flag`, go to RUN.
  - `pixel_de` without `pixel_start_flag` yields BLANK_RGB and no pop.
- **RUN**
  - `pixel_de` with a non-empty head entry having sof=0: pop it and register its data onto `rgb_data`.
  - `pixel_de` with the FIFO empty: output BLANK_RGB and increment `underflow_cnt` (saturating at 16'hFFFF); stay in RUN.
  - `pixel_de` with head sof=1: the upstream frame was short. Do not pop, output BLANK_RGB, pulse `frame_err`, go to ARMED.
- **`pixel_start_flag` in RUN**
  - If the head entry has sof=1, stay in RUN; the SOF pixel is consumed by the next `pixel_de`.
  - Otherwise the upstream frame was long: pulse `frame_err` and go to WAIT_SOF.
- **`pixel_start_flag` in WAIT_SOF**: ignored, no error.
- **`pixel_start_flag` and `pixel_de` in the same cycle**: the flag is evaluated first. ARMED+flag+de enters RUN and pops the SOF pixel in that same cycle.
- **First pixel of a frame**: the SOF entry itself is popped by the first `pixel_de` of the frame only; it is never discarded.
- **No request**: `rgb_data` holds its last value when `pixel_de` is low.

## Timing
- Reset values: `rgb_data` = 24'h0, `frame_err` = 0, `underflow_cnt` = 0, state = WAIT_SOF, FIFO empty, `s_ready` = 0 while `rstin` is high.
- After `rstin` deasserts, `s_ready` = 1 in the first cycle.
- Request latency: `pixel_de` sampled high at edge N gives the requested pixel on `rgb_data` after edge N (one cycle).
- Push-to-pop latency: a pixel pushed at edge N is visible at the head and poppable at edge N+1.
- `frame_err` is registered and asserts the cycle after the detecting edge.
- `underflow_cnt` updates at the same edge as the BLANK_RGB output.
- Reset asserted mid-frame: all state is cleared asynchronously, FIFO contents are discarded, and the block restarts in WAIT_SOF.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Shared package `hdmi_pkg`:
  - state enum `feeder_state_t` {WAIT_SOF, ARMED, RUN};
  - `RGB_W` = 24;
  - default `BLANK_RGB`.
- Sub-module `sync_fifo`, parameterised by width and depth:
  - ports: push, pop, full, empty, head data;
  - single-clock, asynchronous active-high reset.
- The state machine and output register live in `rgb_stream_feeder`.

## Test plan
- **Basic frame**: push a 4-pixel frame 0x000001..0x000004 (sof on the first pixel), pulse `pixel_start_flag`, then 4 `pixel_de` cycles → `rgb_data` = 1, 2, 3, 4 on consecutive cycles, each one cycle after its `pixel_de`; `frame_err` stays 0.
- **Pre-SOF garbage**: push 3 pixels with sof=0, then a frame → the 3 pixels are discarded in WAIT_SOF; the first `pixel_de` after the start flag yields the SOF pixel.
- **Underflow**: in RUN with an empty FIFO, 5 `pixel_de` cycles → `rgb_data` = 24'h000000 each cycle; `underflow_cnt` = 5.
- **Short upstream frame**: frame of 2 pixels followed by the next SOF, 3 `pixel_de` cycles → the 3rd yields BLANK_RGB, `frame_err` pulses, state goes to ARMED, and the next frame aligns on its start flag.
- **Backpressure and full**: fill DEPTH entries with no pops → `s_ready` = 0 and the 17th pixel is not accepted; one pop with `s_valid` held → `s_ready` returns to 1 the next cycle and no data is lost.
- **Reset mid-frame and simultaneous events**: assert `rstin` during RUN → all outputs return to reset values immediately. In a separate case, drive `pixel_start_flag` and `pixel_de` in the same ARMED cycle → the SOF pixel is output the next cycle.

Source files
------------

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: definitions shared by the pixel feeder and its FIFO.
//   RGB_W              - width of one RGB888 pixel {R,G,B}
//   BLANK_RGB_DEFAULT  - pixel value shown when nothing valid can be shown
//   feeder_state_t     - frame alignment states of rgb_stream_feeder
//   fifo_entry_t       - one buffered pixel: {sof, data}
package hdmi_pkg;

  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] BLANK_RGB_DEFAULT = 24'h000000;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic             sof;
    logic [RGB_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head (first-word
// fall-through), so an entry written at edge N can be popped at edge N+1.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset (empties the FIFO)
//   push_i   - write wdata_i; ignored while full, even if popping that cycle
//   wdata_i  - entry to write
//   pop_i    - remove the head entry; ignored while empty
//   full_o   - DEPTH entries stored
//   empty_o  - no entries stored
//   head_o   - oldest stored entry (undefined while empty)
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Head is read combinationally: the consumer decides to pop based on it
  // in the same cycle.
  assign head_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rgb_stream_feeder.sv
// rgb_stream_feeder: buffers an upstream valid/ready RGB888 stream with
// start-of-frame markers and hands out one pixel per pixel_de request,
// aligning each buffered frame to the timing generator's pixel_start_flag.
// Ports:
//   clkin            - pixel clock
//   rstin            - asynchronous active-high reset
//   s_data/s_sof     - upstream pixel and its first-of-frame marker
//   s_valid/s_ready  - upstream handshake
//   pixel_start_flag - one-cycle frame start pulse from the timing generator
//   pixel_de         - active-video pixel request
//   rgb_data         - registered pixel, one cycle after pixel_de
//   frame_err        - one-cycle pulse on short/long upstream frame
//   underflow_cnt    - saturating count of requests made while empty in RUN
module rgb_stream_feeder
  import hdmi_pkg::*;
#(
  parameter int               DEPTH     = 16,
  parameter logic [RGB_W-1:0] BLANK_RGB = BLANK_RGB_DEFAULT
) (
  input  logic             clkin,
  input  logic             rstin,
  input  logic [RGB_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             pixel_start_flag,
  input  logic             pixel_de,
  output logic [RGB_W-1:0] rgb_data,
  output logic             frame_err,
  output logic [15:0]      underflow_cnt
);

  fifo_entry_t   wr_entry;
  fifo_entry_t   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  feeder_state_t    state_q, state_d;
  logic             sof_pend_q, sof_pend_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             rgb_load;
  logic             err_q, err_d;
  logic [15:0]      ucnt_q;
  logic             uf_inc;

  logic head_is_sof;
  logic head_is_data;
  logic start_ok;

  assign s_ready  = ~fifo_full & ~rstin;
  assign push     = s_valid & s_ready;
  assign wr_entry = '{sof: s_sof, data: s_data};

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clkin),
    .rst_i   (rstin),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign head_is_sof  = ~fifo_empty & head.sof;
  assign head_is_data = ~fifo_empty & ~head.sof;

  // In RUN a SOF head may only be consumed once the frame start has been
  // seen: either in this very cycle or remembered from an earlier flag.
  assign start_ok = sof_pend_q | pixel_start_flag;

  always_comb begin
    state_d    = state_q;
    sof_pend_d = sof_pend_q;
    pop        = 1'b0;
    rgb_load   = 1'b0;
    rgb_d      = BLANK_RGB;
    err_d      = 1'b0;
    uf_inc     = 1'b0;

    case (state_q)
      WAIT_SOF: begin
        // Drop everything up to the next frame start; start flag ignored.
        if (head_is_data) begin
          pop = 1'b1;
        end else if (head_is_sof) begin
          state_d = ARMED;
        end
        rgb_load = pixel_de;
      end

      ARMED: begin
        if (pixel_start_flag) begin
          state_d = RUN;
          if (pixel_de) begin
            pop        = 1'b1;
            rgb_load   = 1'b1;
            rgb_d      = head.data;
            sof_pend_d = 1'b0;
          end else begin
            sof_pend_d = 1'b1;
          end
        end else begin
          rgb_load = pixel_de;
        end
      end

      RUN: begin
        if (pixel_start_flag && !head_is_sof) begin
          // Timing generator started a new frame before upstream did: the
          // upstream frame is long. Resynchronise on the next SOF.
          err_d      = 1'b1;
          state_d    = WAIT_SOF;
          sof_pend_d = 1'b0;
          rgb_load   = pixel_de;
        end else if (pixel_de) begin
          rgb_load = 1'b1;
          if (fifo_empty) begin
            uf_inc = 1'b1;
          end else if (head.sof && !start_ok) begin
            // Next frame arrived before this one was fully displayed.
            err_d   = 1'b1;
            state_d = ARMED;
          end else begin
            pop        = 1'b1;
            rgb_d      = head.data;
            sof_pend_d = 1'b0;
          end
        end else if (pixel_start_flag) begin
          sof_pend_d = 1'b1;
        end
      end

      default: begin
        state_d    = WAIT_SOF;
        sof_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      state_q    <= WAIT_SOF;
      sof_pend_q <= 1'b0;
      rgb_q      <= '0;
      err_q      <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sof_pend_q <= sof_pend_d;
      err_q      <= err_d;
      if (rgb_load) begin
        rgb_q <= rgb_d;
      end
      if (uf_inc && (ucnt_q != 16'hFFFF)) begin
        ucnt_q <= ucnt_q + 16'd1;
      end
    end
  end

  assign rgb_data      = rgb_q;
  assign frame_err     = err_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_rgb_stream_feeder.sv
// Testbench for rgb_stream_feeder: directed frames plus randomized frames.
// Expected pixels are queued when a pixel_de request is issued; a monitor
// pops and compares one cycle later.
module tb_rgb_stream_feeder;

  localparam int          DEPTH = 16;
  localparam logic [23:0] BLANK = 24'h000000;

  logic        clkin = 1'b0;
  logic        rstin = 1'b1;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        pixel_start_flag = 1'b0;
  logic        pixel_de = 1'b0;
  logic [23:0] rgb_data;
  logic        frame_err;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int failures = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  logic [23:0] exp_q[$];

  rgb_stream_feeder #(
    .DEPTH     (DEPTH),
    .BLANK_RGB (BLANK)
  ) dut (
    .clkin            (clkin),
    .rstin            (rstin),
    .s_data           (s_data),
    .s_sof            (s_sof),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .pixel_start_flag (pixel_start_flag),
    .pixel_de         (pixel_de),
    .rgb_data         (rgb_data),
    .frame_err        (frame_err),
    .underflow_cnt    (underflow_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s ok: %0h", name, act);
    end
  endtask

  // Monitor: a request sampled at a rising edge is compared at the
  // following falling edge against the oldest queued expectation.
  initial begin : monitor
    logic        de_s;
    logic [23:0] e;
    forever begin
      @(posedge clkin);
      de_s = pixel_de;
      @(negedge clkin);
      if (frame_err) ferr_seen++;
      if (de_s && !rstin) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rgb_unexpected: got %h with nothing expected", rgb_data);
        end else begin
          e = exp_q.pop_front();
          if (rgb_data !== e) begin
            failures++;
            $display("FAIL rgb_pixel: got %h expected %h", rgb_data, e);
          end else begin
            $display("pixel rgb=%h", rgb_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_px(input logic [23:0] d, input logic sof);
    bit hs;
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    do begin
      hs = s_ready;
      tick();
      guard++;
    end while (!hs && guard < 200);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got s_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic de_px(input logic flag, input logic [23:0] e);
    pixel_de = 1'b1;
    pixel_start_flag = flag;
    exp_q.push_back(e);
    tick();
    pixel_de = 1'b0;
    pixel_start_flag = 1'b0;
  endtask

  task automatic flag_only();
    pixel_start_flag = 1'b1;
    tick();
    pixel_start_flag = 1'b0;
  endtask

  task automatic do_reset();
    idle(2);
    check("queue_drained", exp_q.size(), 0);
    check("frame_err_count", ferr_seen, ferr_exp);
    rstin = 1'b1;
    idle(2);
    rstin = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    logic [23:0] frame[$];
    int len;

    // Reset values while rstin is held
    #2;
    check("rst_rgb", rgb_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ucnt", underflow_cnt, 0);
    check("rst_s_ready", s_ready, 0);
    @(posedge clkin);
    #1;
    rstin = 1'b0;
    #1;
    check("ready_after_rst", s_ready, 1);
    tick();

    // Basic frame
    push_px(24'h000001, 1'b1);
    push_px(24'h000002, 1'b0);
    push_px(24'h000003, 1'b0);
    push_px(24'h000004, 1'b0);
    idle(2);
    flag_only();
    for (int i = 1; i <= 4; i++) de_px(1'b0, 24'(i));
    idle(2);
    check("basic_frame_err", ferr_seen, ferr_exp);

    // Underflow in RUN with an empty FIFO
    for (int i = 0; i < 5; i++) de_px(1'b0, BLANK);
    idle(1);
    check("underflow_cnt", underflow_cnt, 5);

    // Long upstream frame: start flag while a non-SOF pixel is at the head
    push_px(24'h00A001, 1'b1);
    push_px(24'h00A002, 1'b0);
    push_px(24'h00A003, 1'b0);
    idle(2);
    flag_only();
    de_px(1'b0, 24'h00A001);
    de_px(1'b0, 24'h00A002);
    flag_only();
    ferr_exp++;
    idle(3);
    push_px(24'h00B001, 1'b1);
    push_px(24'h00B002, 1'b0);
    idle(2);
    flag_only();
    de_px(1'b0, 24'h00B001);
    de_px(1'b0, 24'h00B002);
    idle(2);
    check("long_frame_err", ferr_seen, ferr_exp);
    check("long_ucnt_kept", underflow_cnt, 5);

    // Pre-SOF garbage discarded
    do_reset();
    push_px(24'h0DEAD1, 1'b0);
    push_px(24'h0DEAD2, 1'b0);
    push_px(24'h0DEAD3, 1'b0);
    push_px(24'h00C001, 1'b1);
    push_px(24'h00C002, 1'b0);
    push_px(24'h00C003, 1'b0);
    idle(2);
    flag_only();
    de_px(1'b0, 24'h00C001);
    de_px(1'b0, 24'h00C002);
    de_px(1'b0, 24'h00C003);

    // Short upstream frame, then simultaneous flag+de in ARMED
    do_reset();
    push_px(24'h00D001, 1'b1);
    push_px(24'h00D002, 1'b0);
    push_px(24'h00E001, 1'b1);
    push_px(24'h00E002, 1'b0);
    push_px(24'h00E003, 1'b0);
    idle(2);
    flag_only();
    de_px(1'b0, 24'h00D001);
    de_px(1'b0, 24'h00D002);
    de_px(1'b0, BLANK);
    ferr_exp++;
    de_px(1'b1, 24'h00E001);
    de_px(1'b0, 24'h00E002);
    de_px(1'b0, 24'h00E003);
    idle(2);
    check("short_frame_err", ferr_seen, ferr_exp);
    check("short_no_underflow", underflow_cnt, 0);

    // Backpressure: fill, hold a 17th pixel, free one slot
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_px(24'h000100 + 24'(i), (i == 0));
    check("full_not_ready", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 24'h000999;
    s_sof   = 1'b0;
    idle(3);
    check("full_held", s_ready, 0);
    de_px(1'b1, 24'h000100);
    check("ready_after_pop", s_ready, 1);
    tick();
    s_valid = 1'b0;
    for (int i = 1; i < DEPTH; i++) de_px(1'b0, 24'h000100 + 24'(i));
    de_px(1'b0, 24'h000999);

    // Reset in the middle of a frame
    do_reset();
    push_px(24'h00F001, 1'b1);
    push_px(24'h00F002, 1'b0);
    push_px(24'h00F003, 1'b1);
    push_px(24'h00F004, 1'b0);
    idle(2);
    flag_only();
    de_px(1'b0, 24'h00F001);
    de_px(1'b0, 24'h00F002);
    idle(1);
    rstin = 1'b1;
    #1;
    check("midrst_rgb", rgb_data, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_ucnt", underflow_cnt, 0);
    check("midrst_s_ready", s_ready, 0);
    idle(2);
    rstin = 1'b0;
    tick();
    push_px(24'h001111, 1'b1);
    push_px(24'h002222, 1'b0);
    idle(2);
    flag_only();
    de_px(1'b0, 24'h001111);
    de_px(1'b0, 24'h002222);

    // Randomized aligned frames with random gaps
    do_reset();
    for (int f = 0; f < 8; f++) begin
      frame.delete();
      len = $urandom_range(1, DEPTH);
      if (f == 0) begin
        int g;
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) push_px(24'($urandom), 1'b0);
      end
      for (int i = 0; i < len; i++) begin
        frame.push_back(24'($urandom));
        idle($urandom_range(0, 1));
        push_px(frame[i], (i == 0));
      end
      idle(2);
      if ($urandom_range(0, 1) == 1) begin
        de_px(1'b1, frame[0]);
      end else begin
        flag_only();
        idle($urandom_range(0, 2));
        de_px(1'b0, frame[0]);
      end
      for (int i = 1; i < len; i++) begin
        idle($urandom_range(0, 2));
        de_px(1'b0, frame[i]);
      end
    end
    idle(3);
    check("rand_frame_err", ferr_seen, ferr_exp);
    check("rand_ucnt", underflow_cnt, 0);
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
